// File: rtl/dm_line_cache_if.sv
// Requester-side and memory-side buses of the direct-mapped line cache.
// master drives the request; slave answers it.
interface dm_line_cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              flush;

    modport master (output req_valid, req_addr, flush, input req_ready, resp_valid, resp_data);
    modport slave  (input req_valid, req_addr, flush, output req_ready, resp_valid, resp_data);
endinterface

interface dm_line_mem_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic [ADDR_W-1:0]            mem_req_addr;
    logic                         mem_resp_valid;
    logic [DATA_W*LINE_WORDS-1:0] mem_resp_data;

    modport master (output mem_req_valid, mem_req_addr, input mem_req_ready, mem_resp_valid, mem_resp_data);
    modport slave  (input mem_req_valid, mem_req_addr, output mem_req_ready, mem_resp_valid, mem_resp_data);
endinterface

// File: rtl/dm_line_cache.sv
// Direct-mapped read-only line cache with miss refill, flush and saturating hit/miss counters.
// Hit: resp 2 cycles after accept; one request in flight; no resp backpressure; mem request held until ready.
module dm_line_cache #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int INDEX_W    = 10,
    parameter int CNT_W      = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    dm_line_cache_if.slave    req,
    dm_line_mem_if.master     mem,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
    localparam int LINE_W = DATA_W * LINE_WORDS;
    localparam int LINES  = 1 << INDEX_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_HIT_RESP  = 3'd2;
    localparam logic [2:0] S_MISS_REQ  = 3'd3;
    localparam logic [2:0] S_MISS_WAIT = 3'd4;
    localparam logic [2:0] S_FILL_RESP = 3'd5;

    logic [2:0]        state;
    logic [LINES-1:0]  valid;
    logic              flush_pend;
    logic [ADDR_W-1:0] addr_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] mem_req_addr_q;

    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [LINE_W-1:0] data_ram [LINES];
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;

    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [OFF_W-1:0]   offset;
    logic [INDEX_W-1:0] in_index;
    logic               accept;
    logic               hit;
    logic               fill;
    logic [DATA_W-1:0]  hit_word;
    logic [DATA_W-1:0]  fill_word;

    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign index    = addr_q[OFF_W +: INDEX_W];
    assign offset   = addr_q[OFF_W-1:0];
    assign in_index = req.req_addr[OFF_W +: INDEX_W];

    assign req.req_ready = (state == S_IDLE) && !req.flush && !flush_pend && !rst_in;
    assign accept        = req.req_valid && req.req_ready;
    assign hit           = valid[index] && (rd_tag == tag);
    assign fill          = (state == S_MISS_WAIT) && mem.mem_resp_valid;

    always_comb begin
        hit_word  = rd_line[int'(offset) * DATA_W +: DATA_W];
        fill_word = mem.mem_resp_data[int'(offset) * DATA_W +: DATA_W];
    end

    assign req.resp_valid    = resp_valid_q;
    assign req.resp_data     = resp_data_q;
    assign mem.mem_req_valid = mem_req_valid_q;
    assign mem.mem_req_addr  = mem_req_addr_q;

    // Tag/data storage: plain RAM, registered read launched on accept.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            rd_tag  <= tag_ram[in_index];
            rd_line <= data_ram[in_index];
        end
        if (fill && !rst_in) begin
            tag_ram[index]  <= tag;
            data_ram[index] <= mem.mem_resp_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= S_IDLE;
            valid           <= '0;
            flush_pend      <= 1'b0;
            addr_q          <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            hit_count       <= '0;
            miss_count      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req.flush || flush_pend) begin
                        valid      <= '0;
                        flush_pend <= 1'b0;
                    end
                    if (accept) begin
                        addr_q <= req.req_addr;
                        state  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + CNT_W'(1);
                        resp_data_q  <= hit_word;
                        resp_valid_q <= 1'b1;
                        state        <= S_HIT_RESP;
                    end else begin
                        if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + CNT_W'(1);
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= {tag, index, {OFF_W{1'b0}}};
                        state           <= S_MISS_REQ;
                    end
                end
                S_HIT_RESP: state <= S_IDLE;
                S_MISS_REQ: begin
                    if (mem.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= S_MISS_WAIT;
                    end
                end
                S_MISS_WAIT: begin
                    // Requested word comes straight off the fill bus, no RAM re-read.
                    if (fill) begin
                        valid[index] <= 1'b1;
                        resp_data_q  <= fill_word;
                        resp_valid_q <= 1'b1;
                        state        <= S_FILL_RESP;
                    end
                end
                S_FILL_RESP: state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase
            if (req.flush && state != S_IDLE) flush_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dm_line_cache.sv
// Randomised bench for dm_line_cache against a line-presence model; a CNT_W=2 twin mirrors the stimulus.
module tb_dm_line_cache;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    dm_line_cache_if #(.ADDR_W(32), .DATA_W(32)) rq ();
    dm_line_mem_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) mm ();
    dm_line_cache_if #(.ADDR_W(32), .DATA_W(32)) rq2 ();
    dm_line_mem_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) mm2 ();

    logic [31:0] hit_count, miss_count;
    logic [1:0]  hit2, miss2;

    dm_line_cache dut (
        .clk_in(clk_in), .rst_in(rst_in), .req(rq.slave), .mem(mm.master),
        .hit_count(hit_count), .miss_count(miss_count)
    );
    dm_line_cache #(.CNT_W(2)) dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .req(rq2.slave), .mem(mm2.master),
        .hit_count(hit2), .miss_count(miss2)
    );

    assign rq2.req_valid      = rq.req_valid;
    assign rq2.req_addr       = rq.req_addr;
    assign rq2.flush          = rq.flush;
    assign mm2.mem_req_ready  = mm.mem_req_ready;
    assign mm2.mem_resp_valid = mm.mem_resp_valid;
    assign mm2.mem_resp_data  = mm.mem_resp_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_resp_cyc = -1;
    logic [31:0] exp_data = '0;
    bit mem_ok = 1'b0;
    logic [31:0] last_mem_addr = '0;

    // Model: which line (tag) each index holds, plus access counts.
    bit          mvalid [1024];
    logic [19:0] mtag   [1024];
    int          m_hits = 0;
    int          m_misses = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if ((a & ~32'h3) == 32'h1004) return 32'hA + (a & 32'h3);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(la + 32'(k));
        return l;
    endfunction

    function automatic logic [1:0] sat2(input int x);
        return (x > 3) ? 2'd3 : 2'(x);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            check("resp_valid_timing", rq.resp_valid, cyc == exp_resp_cyc);
            check("resp_valid_timing_cnt2", rq2.resp_valid, cyc == exp_resp_cyc);
            check("resp_with_ready", rq.resp_valid & rq.req_ready, 0);
            if (!mem_ok) check("mem_req_valid_unexpected", mm.mem_req_valid, 0);
            if (rq.resp_valid) begin
                check("resp_data", rq.resp_data, exp_data);
                check("hit_count", hit_count, m_hits);
                check("miss_count", miss_count, m_misses);
            end
            if (rq2.resp_valid) begin
                check("resp_data_cnt2", rq2.resp_data, exp_data);
                check("hit_count_sat", hit2, sat2(m_hits));
                check("miss_count_sat", miss2, sat2(m_misses));
            end
        end
    end

    // mode 0: plain, 1: flush in MISS_WAIT alongside the fill, 2: reset in MISS_WAIT
    task automatic do_read(input logic [31:0] addr, input int ready_lag, input int resp_lag,
                           input int mode, output logic [31:0] got, output bit was_miss);
        int n;
        int k;
        int idx;
        bit hit;
        idx = int'(addr[11:2]);
        got = '0;
        was_miss = 1'b0;
        rq.req_valid = 1'b1;
        rq.req_addr  = addr;
        #1;
        n = 0;
        while (!rq.req_ready && n < 50) begin
            tick(); #1; n++;
        end
        check("accept", rq.req_ready, 1);
        if (!rq.req_ready) begin
            rq.req_valid = 1'b0;
            return;
        end
        k = cyc;
        hit = mvalid[idx] && (mtag[idx] == addr[31:12]);
        was_miss = !hit;
        exp_data = mem_word(addr);
        if (hit) begin
            m_hits++;
            exp_resp_cyc = k + 2;
        end else begin
            m_misses++;
            mem_ok = 1'b1;
        end
        tick();
        rq.req_valid = 1'b0;
        tick();
        if (hit) begin
            got = rq.resp_data;
            return;
        end
        n = 0;
        while (!mm.mem_req_valid && n < 10) begin
            tick(); n++;
        end
        check("mem_req_valid_up", mm.mem_req_valid, 1);
        check("mem_req_addr", mm.mem_req_addr, {addr[31:2], 2'b00});
        last_mem_addr = mm.mem_req_addr;
        repeat (ready_lag) begin
            tick();
            check("mem_req_valid_held", mm.mem_req_valid, 1);
            check("mem_req_addr_held", mm.mem_req_addr, {addr[31:2], 2'b00});
        end
        mm.mem_req_ready = 1'b1;
        tick();
        mm.mem_req_ready = 1'b0;
        check("mem_req_valid_drop", mm.mem_req_valid, 0);
        mem_ok = 1'b0;
        repeat (resp_lag) tick();
        mm.mem_resp_data = mem_line({addr[31:2], 2'b00});
        if (mode == 2) begin
            rst_in = 1'b1;
            #1 check("req_ready_in_reset", rq.req_ready, 0);
            tick();
            rst_in = 1'b0;
            model_clear();
            m_hits = 0;
            m_misses = 0;
            mm.mem_resp_valid = 1'b1;
            tick();
            mm.mem_resp_valid = 1'b0;
            repeat (3) tick();
            check("hit_count_after_reset", hit_count, 0);
            check("miss_count_after_reset", miss_count, 0);
            return;
        end
        mm.mem_resp_valid = 1'b1;
        if (mode == 1) rq.flush = 1'b1;
        exp_resp_cyc = cyc + 1;
        mvalid[idx] = 1'b1;
        mtag[idx]   = addr[31:12];
        if (mode == 1) model_clear();
        tick();
        mm.mem_resp_valid = 1'b0;
        rq.flush = 1'b0;
        got = rq.resp_data;
    endtask

    task automatic do_flush();
        rq.flush = 1'b1;
        #1 check("flush_blocks_ready", rq.req_ready, 0);
        tick();
        rq.flush = 1'b0;
        model_clear();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_req_ready", rq.req_ready, 0);
        check("rst_resp_valid", rq.resp_valid, 0);
        check("rst_resp_data", rq.resp_data, 0);
        check("rst_mem_req_valid", mm.mem_req_valid, 0);
        check("rst_mem_req_addr", mm.mem_req_addr, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        model_clear();
        m_hits = 0;
        m_misses = 0;
        exp_resp_cyc = -1;
        mem_ok = 1'b0;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete (checks=%0d)", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        bit miss;
        logic [31:0] a;
        rq.req_valid = 1'b0;
        rq.req_addr = '0;
        rq.flush = 1'b0;
        mm.mem_req_ready = 1'b0;
        mm.mem_resp_valid = 1'b0;
        mm.mem_resp_data = '0;
        tick();
        do_reset();

        do_read(32'h1005, 0, 0, 0, got, miss);
        check("cold_miss_flag", miss, 1);
        check("cold_mem_addr", last_mem_addr, 32'h1004);
        check("cold_data", got, 32'hB);
        check("cold_miss_count", miss_count, 1);
        check("cold_hit_count", hit_count, 0);

        do_read(32'h1007, 0, 0, 0, got, miss);
        check("hit_flag", miss, 0);
        check("hit_data", got, 32'hD);
        check("hit_count_1", hit_count, 1);

        do_read(32'h2005, 1, 1, 0, got, miss);
        check("conflict_miss_a", miss, 1);
        do_read(32'h1005, 0, 0, 0, got, miss);
        check("conflict_miss_b", miss, 1);
        check("conflict_mem_addr", last_mem_addr, 32'h1004);
        check("conflict_miss_count", miss_count, 3);

        repeat (2) tick();
        rq.req_valid = 1'b1;
        rq.req_addr = 32'h1007;
        do_flush();
        do_read(32'h1007, 0, 0, 0, got, miss);
        check("after_flush_miss", miss, 1);
        check("after_flush_data", got, 32'hD);

        do_read(32'h3001, 0, 2, 1, got, miss);
        check("flush_wait_data", got, mem_word(32'h3001));
        do_read(32'h3001, 0, 0, 0, got, miss);
        check("flush_wait_next_miss", miss, 1);

        do_read(32'h4008, 5, 2, 0, got, miss);
        do_read(32'h5000, 1, 1, 2, got, miss);
        do_read(32'h5000, 0, 0, 0, got, miss);
        check("post_reset_miss", miss, 1);

        do_reset();
        do_read(32'h40, 0, 0, 0, got, miss);
        for (int i = 0; i < 5; i++) do_read(32'h40 + 32'(i % 4), 0, 0, 0, got, miss);
        repeat (2) tick();
        check("sat_hit_count", hit2, 2'd3);
        check("sat_miss_count", miss2, 2'd1);
        check("wide_hit_count", hit_count, 5);

        for (int i = 0; i < 300; i++) begin
            a = {12'(0), 8'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) do_flush();
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 15) == 0) ? 1 : 0, got, miss);
            if ($urandom_range(0, 3) == 0) tick();
        end
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
